sync_ctrl: RTL

//   Sequencer for the OFDM RX preamble-sync front end. Arms the short-preamble detector on

---
 rtl/sync_ctrl_pkg.sv | 11 +
 rtl/sync_ctrl_sat_counter.sv | 14 +
 rtl/sync_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/sync_ctrl_pkg.sv
// sync_ctrl_pkg: state encoding shared by the preamble-sync sequencer
package sync_ctrl_pkg;
   localparam int STATE_WIDTH = 3;
   typedef enum logic [STATE_WIDTH-1:0] {
      S_IDLE      = 3'd0,
      S_SEARCH    = 3'd1,
      S_WAIT_LONG = 3'd2,
      S_LOCKED    = 3'd3,
      S_HOLDOFF   = 3'd4
   } state_t;
endpackage

// File: rtl/sync_ctrl_sat_counter.sv
// sat_counter: up-counter with synchronous clear that sticks at all-ones
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);
   always_ff @(posedge clock)
      if (reset || clr) count <= '0;
      else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/sync_ctrl.sv
// sync_ctrl: sequences short/long preamble detectors from power trigger to lock and flush
module sync_ctrl
   import sync_ctrl_pkg::*;
#(
   parameter int HOLDOFF_CYCLES = 32,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [31:0]          min_plateau_cfg,
   input  logic [CNT_WIDTH-1:0] long_timeout,
   input  logic                 sample_in_strobe,
   input  logic                 power_trigger,
   input  logic                 short_detected,
   input  logic [31:0]          short_phase_offset,
   input  logic                 long_detected,
   input  logic                 pkt_done,
   output logic                 short_rst,
   output logic                 short_en,
   output logic [31:0]          min_plateau,
   output logic                 long_rst,
   output logic                 long_en,
   output logic [31:0]          phase_offset,
   output logic                 locked,
   output logic                 sync_fail,
   output logic [2:0]           state_out,
   output logic [CNT_WIDTH-1:0] short_det_cnt,
   output logic [CNT_WIDTH-1:0] fail_cnt
);
   localparam int HW = HOLDOFF_CYCLES > 1 ? $clog2(HOLDOFF_CYCLES) : 1;
   localparam logic [HW-1:0] HINIT = HW'(HOLDOFF_CYCLES - 1);
   state_t state, nxt;
   logic [HW-1:0] hcnt;
   logic [CNT_WIDTH-1:0] tcnt;
   logic wait_long, timeout, lock_take, fail_take, short_take, abort;
   logic d_rst, d_short_en, d_long_en, d_locked;
   assign wait_long  = state == S_WAIT_LONG;
   assign timeout    = wait_long && sample_in_strobe && tcnt == long_timeout;
   assign lock_take  = wait_long && long_detected && !pkt_done;
   assign fail_take  = timeout && !long_detected && !pkt_done;
   assign abort      = pkt_done && (state == S_SEARCH || wait_long || state == S_LOCKED);
   // a retrigger in WAIT_LONG only counts when nothing of higher priority fired
   assign short_take = short_detected && !pkt_done &&
                       (state == S_SEARCH || (wait_long && !long_detected && !timeout));
   assign state_out  = state;
   always_ff @(posedge clock)
      if (reset) begin
         state        <= S_HOLDOFF;
         hcnt         <= HINIT;
         short_rst    <= 1'b1;
         long_rst     <= 1'b1;
         short_en     <= 1'b0;
         long_en      <= 1'b0;
         locked       <= 1'b0;
         sync_fail    <= 1'b0;
         phase_offset <= '0;
         min_plateau  <= '0;
      end else if (enable) begin
         state        <= nxt;
         hcnt         <= state == S_HOLDOFF ? hcnt - 1'b1 : HINIT;
         short_rst    <= d_rst;
         long_rst     <= d_rst;
         short_en     <= d_short_en;
         long_en      <= d_long_en;
         locked       <= d_locked;
         sync_fail    <= fail_take;
         phase_offset <= short_take ? short_phase_offset : phase_offset;
         min_plateau  <= min_plateau_cfg;
      end else begin
         sync_fail    <= 1'b0;
      end
   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:      nxt = power_trigger ? S_SEARCH : S_IDLE;
         S_SEARCH:    nxt = abort ? S_HOLDOFF : short_take ? S_WAIT_LONG :
                            !power_trigger ? S_IDLE : S_SEARCH;
         S_WAIT_LONG: nxt = abort ? S_HOLDOFF : lock_take ? S_LOCKED :
                            fail_take ? S_HOLDOFF : S_WAIT_LONG;
         S_LOCKED:    nxt = abort ? S_HOLDOFF : S_LOCKED;
         S_HOLDOFF:   nxt = hcnt == '0 ? S_IDLE : S_HOLDOFF;
         default:     nxt = S_HOLDOFF;
      endcase
   end
   // outputs are decoded from the next state so they register alongside it
   always_comb begin
      d_rst      = nxt == S_HOLDOFF;
      d_short_en = nxt == S_SEARCH || nxt == S_WAIT_LONG;
      d_long_en  = nxt == S_WAIT_LONG || nxt == S_LOCKED;
      d_locked   = nxt == S_LOCKED;
   end
   sat_counter #(.WIDTH(CNT_WIDTH)) u_short_cnt (
      .clock(clock), .reset(reset), .clr(1'b0),
      .inc(enable && short_take), .count(short_det_cnt)
   );
   sat_counter #(.WIDTH(CNT_WIDTH)) u_fail_cnt (
      .clock(clock), .reset(reset), .clr(1'b0),
      .inc(enable && fail_take), .count(fail_cnt)
   );
   sat_counter #(.WIDTH(CNT_WIDTH)) u_timeout_cnt (
      .clock(clock), .reset(reset), .clr(enable && short_take),
      .inc(enable && wait_long && sample_in_strobe), .count(tcnt)
   );
endmodule
